median_uart_tx: RTL
===================

Name: median_uart_tx

Overview:
Transmit end of the median filter output stream. Captures each 16-bit median value strobed by median_en into a small FIFO. Serialises each value as two 8N1 UART frames, high byte first. Sits between the median filter and the board UART pin, so the host receives the filtered samples.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535
FIFO_DEPTH, 4, number of 16-bit words buffered; power of two, minimum 2

Ports:
clk  input  1  system clock, all logic on its rising edge
rst  input  1  asynchronous, active-high reset
median  input  16  value to transmit, valid when median_en=1
median_en  input  1  single-cycle write strobe; each cycle high is one independent word
tx  output  1  UART serial line, idle high, registered
busy  output  1  high while the FIFO is non-empty or the FSM is not IDLE
overflow  output  1  one-cycle pulse when a strobed word is dropped because the FIFO is full

Behaviour:
- Reset (async assert, sync release): tx=1, busy=0, overflow=0, FIFO empty, FSM=IDLE, all counters 0. A reset asserted mid-frame drives tx high immediately and discards the partial frame and all buffered words.
- FIFO: circular buffer with write/read pointers and a count of width clog2(FIFO_DEPTH)+1. Pointers wrap at FIFO_DEPTH.
- Push rule: median_en=1 and (count<FIFO_DEPTH or pop in the same cycle) writes median. Otherwise the word is dropped and overflow=1 for exactly that following cycle. A simultaneous push and pop leaves count unchanged.
- FSM states: IDLE, START, DATA, STOP, plus a byte_sel flag (0 = high byte, 1 = low byte).
- IDLE: if count>0, pop the word and hold it in a 16-bit holding register. Load the shifter with bits [15:8], set byte_sel=0, drive tx=0, go to START. This happens on the first edge after the push edge, so tx falls one clock after the edge that sampled median_en.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_cnt=0.
- DATA: tx=shifter[0] for CLKS_PER_BIT cycles per bit, LSB first, shifting right. After bit 7, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. At the end of STOP:
  - byte_sel=0: load bits [7:0], set byte_sel=1, go to START with no idle gap.
  - byte_sel=1 and count>0: pop the next word and go directly to START.
  - otherwise: go to IDLE.
- Baud counter runs from 0 to CLKS_PER_BIT-1 and restarts on every bit boundary. Every bit, including start and stop, lasts exactly CLKS_PER_BIT cycles.
- One word takes exactly 20*CLKS_PER_BIT cycles.
- The pop always occurs at the same edge the FSM leaves IDLE or STOP. The holding register is never overwritten while a word is in flight.
- busy = (state!=IDLE) or (count>0), registered.
- median is sampled only when median_en=1. Its value at other times is ignored, including X.

Test Plan:
1. CLKS_PER_BIT=4. Reset, then one strobe with median=0xA55A.
   - tx falls 1 clk after the strobe edge.
   - Line sequence is 0, 1,0,1,0,0,1,0,1, 1, 0, 0,1,0,1,1,0,1,0, 1, with each bit held for 4 clks.
   - Total frame time is 80 clks, then tx=1 and busy=0.
2. Strobes of 0x0000 and then 0xFFFF, 3 clks apart.
   - Both words are sent back to back with no idle gap between the 4 frames.
   - Data bits are all-0 then all-1, and stop bits are always 1.
3. FIFO_DEPTH=4. Strobes on 6 consecutive cycles with values 0x0001..0x0006.
   - 0x0001..0x0005 are transmitted in order.
   - 0x0006 is dropped, with overflow=1 for exactly one cycle after its strobe edge.
4. FIFO full, and a strobe coincides with the pop at the end of the low-byte STOP.
   - The word is accepted and overflow stays 0.
5. Assert rst for 1 clk during DATA of the high byte of 0x1234, while 2 words are queued.
   - tx=1 immediately, busy=0, and nothing is transmitted afterwards.
   - A new strobe of 0x00FF is then sent correctly.
6. CLKS_PER_BIT=2 with continuous random strobes every 40 clks.
   - A scoreboard UART receiver reassembles every 16-bit word with zero mismatches and overflow never asserts.

Source files
------------

// File: rtl/median_uart_tx.sv
// median_uart_tx: buffers 16-bit median samples in a small FIFO and sends
// each one as two 8N1 UART frames, high byte first, with no gap between the
// two frames of a word or between consecutive queued words.
module median_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] median,
  input  logic        median_en,
  output logic        tx,
  output logic        busy,
  output logic        overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0]      BAUD_ONE  = 16'd1;
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // FSM / shifter state
  state_t      state_q;
  logic [15:0] baud_q;
  logic [2:0]  bit_cnt_q;
  logic        byte_sel_q;
  logic [7:0]  shift_q;
  logic [15:0] hold_q;
  logic        tx_q;

  // FIFO state
  logic [15:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Status registers
  logic busy_q;
  logic busy_d;
  logic ovf_q;

  logic        baud_end;
  logic        fifo_nonempty;
  logic        pop;
  logic        push;
  logic        going_idle;
  logic [15:0] rd_word;

  // Pop/push decisions and next FIFO occupancy; a pop only happens when the
  // FSM leaves IDLE or finishes the low-byte stop bit, so the holding
  // register is reloaded only once the previous word is fully on the line.
  always_comb begin
    baud_end      = (baud_q == BAUD_LAST);
    fifo_nonempty = (count_q != '0);
    rd_word       = mem_q[rd_ptr_q];
    pop           = 1'b0;
    going_idle    = 1'b0;
    case (state_q)
      S_IDLE: begin
        pop        = fifo_nonempty;
        going_idle = !fifo_nonempty;
      end
      S_STOP: begin
        if (baud_end && byte_sel_q) begin
          pop        = fifo_nonempty;
          going_idle = !fifo_nonempty;
        end
      end
      default: begin
        pop        = 1'b0;
        going_idle = 1'b0;
      end
    endcase
    // A full FIFO still accepts a word when a slot frees up on the same edge.
    push    = median_en && ((count_q != CNT_FULL) || pop);
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
    busy_d = !going_idle || (count_d != '0);
  end

  // FIFO storage; contents need no reset since the count marks validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= median;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q <= count_d;
    end
  end

  // UART framing FSM: every bit (start, data, stop) lasts CLKS_PER_BIT clocks
  // because the baud counter restarts on each bit boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_cnt_q  <= '0;
      byte_sel_q <= 1'b0;
      shift_q    <= '0;
      hold_q     <= '0;
      tx_q       <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            hold_q     <= rd_word;
            shift_q    <= rd_word[15:8];
            byte_sel_q <= 1'b0;
            baud_q     <= '0;
            tx_q       <= 1'b0;
            state_q    <= S_START;
          end
        end
        S_START: begin
          if (baud_end) begin
            baud_q    <= '0;
            bit_cnt_q <= '0;
            tx_q      <= shift_q[0];
            state_q   <= S_DATA;
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        S_DATA: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_cnt_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        S_STOP: begin
          if (baud_end) begin
            baud_q <= '0;
            if (!byte_sel_q) begin
              // High byte done: low byte follows with no idle gap.
              shift_q    <= hold_q[7:0];
              byte_sel_q <= 1'b1;
              tx_q       <= 1'b0;
              state_q    <= S_START;
            end else if (pop) begin
              hold_q     <= rd_word;
              shift_q    <= rd_word[15:8];
              byte_sel_q <= 1'b0;
              tx_q       <= 1'b0;
              state_q    <= S_START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Registered status: busy reflects next-cycle FSM/FIFO state, overflow
  // pulses for one cycle after a dropped strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      ovf_q  <= median_en && !push;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule
